// File: rtl/rgb_led_axil_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rgb_led_axil_slave
// Brief    : AXI4-Lite register slave driving three PWM RGB LED outputs.
//            Optional macro RGB_LED_STATUS_EN adds a read-only STATUS at 0x10.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_led_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int PWM_BITS           = 8
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            LED_R,
    output logic                            LED_G,
    output logic                            LED_B
);
    localparam int DW        = C_S_AXI_DATA_WIDTH;
    localparam int NUM_REGS  = 4;
    localparam int NUM_LANES = C_S_AXI_DATA_WIDTH / 8;

    logic [DW-1:0]          regs_q [NUM_REGS];
    logic [DW-1:0]          regs_d [NUM_REGS];
    logic                   aw_hold_q, aw_hold_d;
    logic [2:0]             aw_idx_q, aw_idx_d;
    logic                   w_hold_q, w_hold_d;
    logic [DW-1:0]          w_data_q, w_data_d;
    logic [NUM_LANES-1:0]   w_strb_q, w_strb_d;
    logic                   bvalid_q, bvalid_d;
    logic                   rvalid_q, rvalid_d;
    logic [DW-1:0]          rdata_q, rdata_d;
    logic [15:0]            presc_cnt_q, presc_cnt_d;
    logic [PWM_BITS-1:0]    pwm_cnt_q, pwm_cnt_d;
    logic [2:0]             led_q, led_d;

    logic                   w_aw_hs, w_w_hs, w_ar_hs;
    logic                   w_en, w_inv, w_tick;
    logic [15:0]            w_prescale;
    logic [DW-1:0]          w_rword;
    logic                   w_unused;

    assign S_AXI_AWREADY = !aw_hold_q && !bvalid_q;
    assign S_AXI_WREADY  = !w_hold_q && !bvalid_q;
    assign S_AXI_ARREADY = !rvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign LED_R         = led_q[0];
    assign LED_G         = led_q[1];
    assign LED_B         = led_q[2];

    assign w_aw_hs    = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs     = S_AXI_WVALID && S_AXI_WREADY;
    assign w_ar_hs    = S_AXI_ARVALID && S_AXI_ARREADY;
    assign w_en       = regs_q[0][0];
    assign w_inv      = regs_q[0][1];
    assign w_prescale = regs_q[0][31:16];
    assign w_tick     = w_en && (presc_cnt_q >= w_prescale);
    assign w_unused   = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                          S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Write path: AW and W park independently; commit one edge after both are held.
    always_comb begin
        aw_hold_d = aw_hold_q;
        aw_idx_d  = aw_idx_q;
        w_hold_d  = w_hold_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
        if (w_aw_hs) begin
            aw_hold_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[4:2];
        end
        if (w_w_hs) begin
            w_hold_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end
        if (aw_hold_q && w_hold_q) begin
            aw_hold_d = 1'b0;
            w_hold_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (!aw_idx_q[2]) begin
                for (int b = 0; b < NUM_LANES; b++) begin
                    if (w_strb_q[b]) begin
                        regs_d[aw_idx_q[1:0]][8*b +: 8] = w_data_q[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        w_rword = '0;
        if (!S_AXI_ARADDR[4]) begin
            w_rword = regs_q[S_AXI_ARADDR[3:2]];
        end
`ifdef RGB_LED_STATUS_EN
        else if (S_AXI_ARADDR[3:2] == 2'd0) begin
            w_rword = {8'h00, presc_cnt_q, 8'(pwm_cnt_q)};
        end
`endif
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        if (w_ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = w_rword;
        end
    end

    always_comb begin
        presc_cnt_d = '0;
        pwm_cnt_d   = '0;
        if (w_en) begin
            presc_cnt_d = w_tick ? 16'd0 : presc_cnt_q + 16'd1;
            pwm_cnt_d   = w_tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        end
        for (int i = 0; i < 3; i++) begin
            led_d[i] = w_inv ^ (w_en && (pwm_cnt_q < regs_q[i+1][PWM_BITS-1:0]));
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            aw_hold_q   <= 1'b0;
            aw_idx_q    <= '0;
            w_hold_q    <= 1'b0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            bvalid_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            presc_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            led_q       <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            aw_hold_q   <= aw_hold_d;
            aw_idx_q    <= aw_idx_d;
            w_hold_q    <= w_hold_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            bvalid_q    <= bvalid_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            presc_cnt_q <= presc_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            led_q       <= led_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rgb_led_axil_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rgb_led_axil_slave
// Brief    : Scoreboard bench for rgb_led_axil_slave (honours RGB_LED_STATUS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_led_axil_slave;
    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [4:0]  S_AXI_AWADDR, S_AXI_ARADDR;
    logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
    logic        S_AXI_AWVALID, S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID, S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY;
    logic        S_AXI_ARVALID, S_AXI_ARREADY;
    logic        S_AXI_RVALID, S_AXI_RREADY;
    logic        LED_R, LED_G, LED_B;

    rgb_led_axil_slave dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .LED_R(LED_R), .LED_G(LED_G), .LED_B(LED_B)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] data;
        string       name;
    } rexp_t;

    rexp_t r_q[$];
    string b_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    commit_cyc = 0;
    rexp_t r_e;
    string b_name;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops an expectation on every R/B handshake.
    always @(negedge ACLK) begin
        if (!ARESET && S_AXI_RVALID && S_AXI_RREADY) begin
            if (r_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_r: got RDATA 0x%08h, expected no response", S_AXI_RDATA);
            end else begin
                r_e = r_q.pop_front();
                check(r_e.name, S_AXI_RDATA, r_e.data);
                check({r_e.name, "_rresp"}, 32'(S_AXI_RRESP), 32'd0);
            end
        end
        if (!ARESET && S_AXI_BVALID && S_AXI_BREADY) begin
            if (b_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_b: got BRESP %0d, expected no response", S_AXI_BRESP);
            end else begin
                b_name = b_q.pop_front();
                check(b_name, 32'(S_AXI_BRESP), 32'd0);
            end
        end
    end

    // Expected STATUS for the AR handshake on the next edge (CTRL = PRESCALE 2, EN 1).
    function automatic logic [31:0] status_model();
        int k;
        k = cyc - commit_cyc;
`ifdef RGB_LED_STATUS_EN
        return {8'h00, 16'(k % 3), 8'((k / 3) % 256)};
`else
        return 32'd0;
`endif
    endfunction

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit track);
        bit aw_ok, w_ok, a, w, done;
        if (track) b_q.push_back($sformatf("bresp_%02h", addr));
        @(posedge ACLK); #1;
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        aw_ok = 0; w_ok = 0;
        for (int n = 0; n < 50 && !(aw_ok && w_ok); n++) begin
            @(negedge ACLK);
            a = S_AXI_AWVALID && S_AXI_AWREADY;
            w = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge ACLK); #1;
            if (a) begin S_AXI_AWVALID = 1'b0; aw_ok = 1; end
            if (w) begin S_AXI_WVALID = 1'b0; w_ok = 1; end
        end
        if (!(aw_ok && w_ok)) begin
            check("aw_w_accept_timeout", {30'd0, aw_ok, w_ok}, 32'd3);
            S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        end
        if (track) begin
            done = 0;
            for (int n = 0; n < 50 && !done; n++) begin
                @(negedge ACLK);
                if (S_AXI_BVALID && S_AXI_BREADY) begin
                    done = 1;
                    commit_cyc = cyc;
                end
                @(posedge ACLK); #1;
            end
            if (!done) check("b_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic axi_read(input logic [4:0] addr, input logic [31:0] exp,
                            input string name, input bit status, input bit track);
        bit got, done;
        logic [31:0] e;
        @(posedge ACLK); #1;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
        got = 0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge ACLK);
            if (S_AXI_ARREADY) begin
                got = 1;
                e = status ? status_model() : exp;
                if (track) r_q.push_back('{e, name});
            end
            @(posedge ACLK); #1;
        end
        S_AXI_ARVALID = 1'b0;
        if (!got) check({name, "_ar_timeout"}, 32'd0, 32'd1);
        if (track) begin
            done = 0;
            for (int n = 0; n < 50 && !done; n++) begin
                @(negedge ACLK);
                done = S_AXI_RVALID && S_AXI_RREADY;
                @(posedge ACLK); #1;
            end
            if (!done) check({name, "_r_timeout"}, 32'd0, 32'd1);
        end
    endtask

    task automatic count_leds(input int cycles, output int r, output int g, output int b);
        r = 0; g = 0; b = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge ACLK);
            r += int'(LED_R); g += int'(LED_G); b += int'(LED_B);
        end
    endtask

    initial begin
        int cr, cg, cb;
        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b1;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b1;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;
        @(negedge ACLK);
        check("rst_awready", 32'(S_AXI_AWREADY), 32'd1);
        check("rst_wready",  32'(S_AXI_WREADY),  32'd1);
        check("rst_arready", 32'(S_AXI_ARREADY), 32'd1);
        check("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
        check("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
        check("rst_rdata",   S_AXI_RDATA,        32'd0);
        check("rst_leds",    {29'd0, LED_B, LED_G, LED_R}, 32'd0);

        // Basic write/readback of all four registers
        for (int i = 0; i < 4; i++) axi_write(5'(4 * i), 32'(i + 1), 4'hF, 1);
        for (int i = 0; i < 4; i++)
            axi_read(5'(4 * i), 32'(i + 1), $sformatf("rd_reg%0d", i), 0, 1);

        // W arrives three cycles ahead of AW; BREADY held low
        S_AXI_BREADY = 1'b0;
        @(posedge ACLK); #1;
        S_AXI_WDATA = 32'h000000AA; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        @(posedge ACLK); #1 S_AXI_WVALID = 1'b0;
        @(posedge ACLK); #1;
        @(posedge ACLK); #1;
        S_AXI_AWADDR = 5'h04; S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        check("early_w_awready", 32'(S_AXI_AWREADY), 32'd1);
        b_q.push_back("bresp_early_w");
        @(posedge ACLK); #1 S_AXI_AWVALID = 1'b0;
        @(negedge ACLK);
        check("early_w_bvalid_n", 32'(S_AXI_BVALID), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("bstall_bvalid",  32'(S_AXI_BVALID),  32'd1);
            check("bstall_awready", 32'(S_AXI_AWREADY), 32'd0);
            check("bstall_wready",  32'(S_AXI_WREADY),  32'd0);
        end
        @(posedge ACLK); #1 S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        axi_read(5'h04, 32'h000000AA, "rd_red_aa", 0, 1);

        // Partial byte strobes
        axi_write(5'h08, 32'h0, 4'hF, 1);
        axi_write(5'h08, 32'h11223344, 4'b0101, 1);
        axi_read(5'h08, 32'h00220044, "rd_strb", 0, 1);

        // PWM: duty 64 / 0 / 255 with PRESCALE 0
        axi_write(5'h04, 32'd64, 4'hF, 1);
        axi_write(5'h08, 32'd0, 4'hF, 1);
        axi_write(5'h0C, 32'd255, 4'hF, 1);
        axi_write(5'h00, 32'h1, 4'hF, 1);
        repeat (4) @(negedge ACLK);
        count_leds(256, cr, cg, cb);
        check("pwm_r_64",  32'(cr), 32'd64);
        check("pwm_g_0",   32'(cg), 32'd0);
        check("pwm_b_255", 32'(cb), 32'd255);
        axi_write(5'h00, 32'h3, 4'hF, 1);
        repeat (4) @(negedge ACLK);
        count_leds(256, cr, cg, cb);
        check("pwm_inv_r", 32'(cr), 32'd192);
        check("pwm_inv_g", 32'(cg), 32'd256);
        check("pwm_inv_b", 32'(cb), 32'd1);
        axi_write(5'h00, 32'h2, 4'hF, 1);
        repeat (4) @(negedge ACLK);
        count_leds(20, cr, cg, cb);
        check("dis_inv_r", 32'(cr), 32'd20);
        check("dis_inv_g", 32'(cg), 32'd20);
        check("dis_inv_b", 32'(cb), 32'd20);

        // Unused words and STATUS
        axi_write(5'h14, 32'hDEADBEEF, 4'hF, 1);
        axi_write(5'h1C, 32'hCAFEF00D, 4'hF, 1);
        axi_read(5'h14, 32'd0, "rd_unused14", 0, 1);
        axi_read(5'h1C, 32'd0, "rd_unused1c", 0, 1);
        axi_write(5'h00, 32'h0, 4'hF, 1);
        repeat (3) @(negedge ACLK);
        axi_write(5'h00, 32'h00020001, 4'hF, 1);
        repeat (10) @(negedge ACLK);
        axi_read(5'h10, 32'd0, "rd_status_a", 1, 1);
        repeat (7) @(negedge ACLK);
        axi_read(5'h10, 32'd0, "rd_status_b", 1, 1);

        // Reset with both responses pending
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        axi_write(5'h04, 32'h55, 4'hF, 0);
        axi_read(5'h04, 32'h0, "rd_pending", 0, 0);
        repeat (3) @(negedge ACLK);
        check("pend_bvalid", 32'(S_AXI_BVALID), 32'd1);
        check("pend_rvalid", 32'(S_AXI_RVALID), 32'd1);
        check("pend_rdata",  S_AXI_RDATA,       32'h55);
        @(posedge ACLK); #1 ARESET = 1'b1;
        @(posedge ACLK); #1 ARESET = 1'b0;
        @(negedge ACLK);
        check("post_rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        check("post_rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
        check("post_rst_leds",   {29'd0, LED_B, LED_G, LED_R}, 32'd0);
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        for (int i = 0; i < 4; i++)
            axi_read(5'(4 * i), 32'd0, $sformatf("post_rst_reg%0d", i), 0, 1);

        repeat (3) @(negedge ACLK);
        check("r_queue_empty", 32'(r_q.size()), 32'd0);
        check("b_queue_empty", 32'(b_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
